// File: rtl/if_stage.sv
// Instruction fetch stage: issues one instruction-memory request at a time,
// buffers the returned word and offers it to decode together with PC, PC+4
// and PC+8. Branch redirects honour a single delay slot.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_allowin_in,
    input  logic        br_taken_in,
    input  logic [31:0] br_target_in,
    output logic        if_valid_out,
    output logic [31:0] if_PC_out,
    output logic [31:0] if_NPC_out,
    output logic [31:0] if_NNPC_out,
    output logic [31:0] if_Instruct_out,
    output logic        if_adel_out,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        adel_q, adel_d;
    logic        brPending_q, brPending_d;
    logic [31:0] brTarget_q, brTarget_d;
    logic        handover;
    logic        pcMisaligned;
    logic [31:0] nextPc;

    // Handover condition and the address of the fetch that follows it;
    // a branch seen in the handover cycle itself wins over a remembered one.
    always_comb begin
        handover     = (state_q == S_HOLD) && id_allowin_in;
        pcMisaligned = (pc_q[1:0] != 2'b00);
        if (br_taken_in) begin
            nextPc = br_target_in;
        end else if (brPending_q) begin
            nextPc = brTarget_q;
        end else begin
            nextPc = pc_q + 32'd4;
        end
    end

    // Fetch FSM: request, wait for data, hold until decode takes the word.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        adel_d  = adel_q;
        case (state_q)
            S_REQ: begin
                if (pcMisaligned) begin
                    state_d = S_HOLD;
                    instr_d = 32'h0;
                    adel_d  = 1'b1;
                end else if (inst_addr_ok) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    state_d = S_HOLD;
                    instr_d = inst_rdata;
                end
            end
            S_HOLD: begin
                if (id_allowin_in) begin
                    state_d = S_REQ;
                    pc_d    = nextPc;
                    adel_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // Remember a taken branch that decode raised before the delay slot left
    // this stage, so the redirect survives until the delay slot is handed over.
    always_comb begin
        brPending_d = brPending_q;
        brTarget_d  = brTarget_q;
        if (handover) begin
            brPending_d = 1'b0;
        end else if (br_taken_in) begin
            brPending_d = 1'b1;
            brTarget_d  = br_target_in;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            instr_q     <= 32'h0;
            adel_q      <= 1'b0;
            brPending_q <= 1'b0;
            brTarget_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            adel_q      <= adel_d;
            brPending_q <= brPending_d;
            brTarget_q  <= brTarget_d;
        end
    end

    // Output decode; request and valid are forced low while reset is held.
    always_comb begin
        inst_req        = rst_n && (state_q == S_REQ) && !pcMisaligned;
        inst_addr       = pc_q;
        if_valid_out    = rst_n && (state_q == S_HOLD);
        if_PC_out       = pc_q;
        if_NPC_out      = pc_q + 32'd4;
        if_NNPC_out     = pc_q + 32'd8;
        if_Instruct_out = instr_q;
        if_adel_out     = adel_q;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'hBFC0_0000, first fetch address after reset.
REQ-002 clk  in  1  clock; all state updates on posedge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 id_allowin_in  in  1  decode stage can accept an instruction this cycle.
REQ-005 br_taken_in  in  1  decode holds a taken branch/jump; combinational, may stay high several cycles.
REQ-006 br_target_in  in  32  target of that branch, valid while br_taken_in=1.
REQ-007 if_valid_out  out  1  fetched instruction held and offered to decode.
REQ-008 if_PC_out / if_NPC_out / if_NNPC_out  out  32 each  fetch PC, PC+4, PC+8.
REQ-009 if_Instruct_out  out  32  fetched instruction word.
REQ-010 if_adel_out  out  1  offered instruction has a misaligned PC (address-error flag).
REQ-011 inst_req  out  1  instruction-memory request.
REQ-012 inst_addr  out  32  request address, equals if_PC_out.
REQ-013 inst_addr_ok  in  1  memory accepted request this cycle.
REQ-014 inst_data_ok  in  1  read data returned this cycle.
REQ-015 inst_rdata  in  32  read data, valid with inst_data_ok.

Function
REQ-016 FSM states: S_REQ, S_WAIT, S_HOLD; one outstanding request maximum.
REQ-017 S_REQ: inst_req=1 when pc[1:0]==0; on inst_addr_ok go S_WAIT.
REQ-018 S_REQ with pc[1:0]!=0: inst_req=0; next cycle S_HOLD with instruction 32'h0 and if_adel_out=1.
REQ-019 S_WAIT: inst_req=0; on inst_data_ok latch inst_rdata into the instruction buffer, go S_HOLD; inst_data_ok never arrives in the same cycle as its inst_addr_ok.
REQ-020 S_HOLD: if_valid_out=1; buffer, PC outputs and if_adel_out are stable until handover.
REQ-021 Handover = S_HOLD && id_allowin_in; at handover pc <= next_pc, state <= S_REQ, if_adel_out <= 0.
REQ-022 if_valid_out=0 in S_REQ and S_WAIT; inst_data_ok outside S_WAIT is ignored.
REQ-023 next_pc priority: br_taken_in ? br_target_in : br_pending ? br_target_r : pc+4.
REQ-024 Delay slot: the instruction handed over while a branch sits in decode is the delay slot; redirect applies only to the fetch after it.
REQ-025 br_pending/br_target_r: set and captured when br_taken_in=1 and no handover in that cycle; cleared at handover; re-capture while pending overwrites with the same target.
REQ-026 Simultaneous br_taken_in and handover: br_target_in used directly, br_pending stays/becomes 0.
REQ-027 PC arithmetic modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0; NPC/NNPC wrap identically.
REQ-028 Throughput: at most one instruction per 3 cycles (S_REQ->S_WAIT->S_HOLD), minimum latency req-accept to if_valid_out = 2 cycles.

Reset
REQ-029 rst_n=0 on posedge: state=S_REQ, pc=RESET_PC, buffer=0, br_pending=0, br_target_r=0, if_adel_out=0.
REQ-030 During and after reset: if_valid_out=0, inst_req=0 while rst_n=0, if_PC_out=RESET_PC, if_NPC_out=RESET_PC+4, if_NNPC_out=RESET_PC+8, if_Instruct_out=0.
REQ-031 Reset mid-operation abandons any outstanding request; the memory is reset by the same rst_n and returns no stale data.

Verification
REQ-032 Reset release, addr_ok same cycle, data_ok next cycle with 32'h2408_0001 -> inst_addr=BFC0_0000, if_valid_out=1 two cycles after accept, if_Instruct_out=2408_0001, NPC=BFC0_0004.
REQ-033 id_allowin_in=0 for 5 cycles in S_HOLD -> all outputs stable, inst_req=0; allowin=1 -> next inst_addr=BFC0_0004.
REQ-034 br_taken_in=1, target 8000_0100, coincident with delay-slot handover at BFC0_0004 -> next inst_addr=8000_0100.
REQ-035 br_taken_in pulses 1 cycle while delay-slot fetch in S_WAIT -> br_pending=1; after handover next inst_addr=target, not PC+4.
REQ-036 Target 8000_0102 -> no inst_req, if_valid_out=1 with if_adel_out=1, instruction 0, PC 8000_0102.
REQ-037 rst_n=0 asserted in S_WAIT -> next cycle state S_REQ, if_valid_out=0, first request after release at BFC0_0000.
